// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Parses frames of the form A5, count_hi, count_lo, count x 4-byte words
// (MSB first), then optionally a checksum byte. The core is held in reset
// (cpu_hold) until a complete, valid image has been written.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over count_hi, count_lo and all data bytes.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [7:0]  MAGIC   = 8'hA5;
    localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    // State entered once the last word (or an empty image) has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FINISH = CHK;
`else
    localparam state_t FINISH = DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic [15:0] count_q;
    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic        accept;
    logic [15:0] count_full;
    logic        last_word;

    assign in_ready   = (state != WRITE);
    assign accept     = in_valid && in_ready;
    assign count_full = {count_q[15:8], in_data};
    assign last_word  = ((words_loaded + 16'd1) == count_q);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q;

    // Running XOR over count and data bytes; cleared by each magic byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= '0;
        end else if (accept) begin
            case (state)
                IDLE, DONE, ERR: if (in_data == MAGIC) chk_q <= '0;
                CNT_HI, CNT_LO, DATA: chk_q <= chk_q ^ in_data;
                default: ;
            endcase
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode from the current state and the accepted byte.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (accept && in_data == MAGIC) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (accept) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (accept) begin
                    if ({1'b0, count_full} > MAX_CNT) state_next = ERR;
                    else if (count_full == '0)        state_next = FINISH;
                    else                              state_next = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                state_next = last_word ? FINISH : DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_next = (in_data == chk_q) ? DONE : ERR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Datapath: count capture, word assembly, write strobe and status flags.
    // Status flags are registered from state_next so they change on the same
    // edge as the state while staying glitch-free toward the core reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= '0;
            byte_idx     <= '0;
            word_q       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
        end else begin
            imem_we  <= 1'b0;
            done     <= (state_next == DONE);
            error    <= (state_next == ERR);
            cpu_hold <= (state_next != DONE);
            case (state)
                IDLE, DONE, ERR: begin
                    if (accept && in_data == MAGIC) words_loaded <= '0;
                end
                CNT_HI: begin
                    if (accept) count_q[15:8] <= in_data;
                end
                CNT_LO: begin
                    if (accept) begin
                        count_q[7:0] <= in_data;
                        byte_idx     <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_q   <= {word_q[23:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_BASE + {14'b0, words_loaded, 2'b00};
                            imem_wdata <= {word_q[23:0], in_data};
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader with a write
// scoreboard. Works with or without LOADER_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader #(.ADDR_BASE(BASE), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] frame_words [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_imem_we"}, 32'(imem_we), 32'd0);
        check({name, "_imem_addr"}, imem_addr, 32'd0);
        check({name, "_imem_wdata"}, imem_wdata, 32'd0);
        check({name, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Pops one expected write per strobe cycle; a strobe with nothing queued fails.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst && imem_we) begin
                check("ready_low_in_write", 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", imem_addr, e.addr);
                    check("wr_data", imem_wdata, e.data);
                end
            end
        end
    endtask

    // Offers one byte after 'gap' idle cycles; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned n;
        n = 0;
        for (int unsigned g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends a full frame from frame_words and queues the expected writes.
    task automatic send_frame(input logic [15:0] count, input int unsigned gap,
                              input logic [7:0] chk_flip);
        logic [7:0]  x;
        logic [7:0]  byt;
        logic [31:0] w;
        wr_t         e;
        x = count[15:8] ^ count[7:0];
        send_byte(8'hA5, gap);
        send_byte(count[15:8], gap);
        send_byte(count[7:0], gap);
        for (int i = 0; i < int'(count); i++) begin
            w = frame_words[i];
            e.addr = BASE + 32'(i) * 32'd4;
            e.data = w;
            exp_q.push_back(e);
            for (int b = 3; b >= 0; b--) begin
                byt = w[b*8 +: 8];
                x   = x ^ byt;
                send_byte(byt, gap);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x ^ chk_flip, gap);
`else
        if (chk_flip != 8'h00) check("chk_flip_unused", 32'(chk_flip), 32'd0);
`endif
    endtask

    // Checks completion timing right after the frame's final byte was accepted.
    task automatic check_done(input string name, input logic [15:0] cnt);
`ifdef LOADER_CHECKSUM_EN
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_hold"}, 32'(cpu_hold), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_words"}, 32'(words_loaded), 32'(cnt));
`else
        if (cnt != 16'd0) begin
            check({name, "_hold_in_write"}, 32'(cpu_hold), 32'd1);
            check({name, "_done_in_write"}, 32'(done), 32'd0);
            check({name, "_words_in_write"}, 32'(words_loaded), 32'(cnt - 16'd1));
            @(posedge clk);
            #1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_hold"}, 32'(cpu_hold), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_words"}, 32'(words_loaded), 32'(cnt));
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset held for 3 cycles, then idle.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("idle");

        // Two-word image.
        frame_words[0] = 32'h2008_0005;
        frame_words[1] = 32'h0000_0000;
        send_frame(16'd2, 0, 8'h00);
        check_done("two_words", 16'd2);

        // Garbage after DONE is discarded.
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        check("garbage_done", 32'(done), 32'd1);
        check("garbage_words", 32'(words_loaded), 32'd2);

        // Empty image reload: done drops on magic, rises on completion.
        send_byte(8'hA5, 0);
        check("reload_done_low", 32'(done), 32'd0);
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_words_clr", 32'(words_loaded), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check_done("empty", 16'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: 0x2C against the correct 0x2F.
        send_frame(16'd2, 0, 8'h03);
        check("badchk_error", 32'(error), 32'd1);
        check("badchk_done", 32'(done), 32'd0);
        check("badchk_hold", 32'(cpu_hold), 32'd1);
        check("badchk_words", 32'(words_loaded), 32'd2);
`endif

        // Oversize count 257.
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        check("oversize_not_yet", 32'(error), 32'd0);
        send_byte(8'h01, 0);
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_hold", 32'(cpu_hold), 32'd1);
        check("oversize_done", 32'(done), 32'd0);
        check("oversize_words", 32'(words_loaded), 32'd0);

        // Count exactly MAX_WORDS is accepted.
        for (int i = 0; i < 256; i++) begin
            frame_words[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
        end
        send_frame(16'h0100, 0, 8'h00);
        check_done("max_words", 16'h0100);

        // Reset after 2 of 4 data bytes.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reload with in_valid toggled every other cycle.
        frame_words[0] = 32'h1234_ABCD;
        send_frame(16'd1, 1, 8'h00);
        check_done("stalled", 16'd1);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
